pod_line_packer: RTL and testbench
==================================

Name: pod_line_packer

Overview:
- Upstream feeder of the pod memory's level-1 (off-chip) write path.
- Accepts D_W-bit beats from one level-2 NoC port with valid/ready handshake and packs consecutive-address beats into one OFFCHIP_DW-bit line.
- Emits each line with its base address and a per-lane valid mask.
- Supplies the data-pack and handshake function that the pod memory itself leaves out.

Parameters:
- D_W, 64, level-2 beat width.
- OFFCHIP_DW, 512, level-1 line width; must be an integer multiple of D_W.
- ADDR_W, 14, beat-granular address width.
- RATIO, OFFCHIP_DW/D_W (8), lanes per line; derived, not overridden.
- CNT_W, $clog2(RATIO)+1 (4), lane-counter width; derived.

Ports:
- clk  in  1  Single clock; all state on rising edge.
- rst  in  1  Reset, asynchronous assert, active-high.
- in_valid  in  1  Beat valid.
- in_ready  out  1  Beat accept.
- in_addr  in  ADDR_W  Beat address.
- in_data  in  D_W  Beat payload.
- in_last  in  1  Close the current line after this beat.
- out_valid  out  1  Line valid.
- out_ready  in  1  Line accept.
- out_addr  out  ADDR_W  Address of lane 0 of the line.
- out_data  out  OFFCHIP_DW  Packed line; lane k occupies [k*D_W +: D_W].
- out_mask  out  RATIO  Bit k set when lane k holds a written beat.

Behaviour:
- State:
  - Assembly buffer: asm_data, asm_addr, asm_cnt (0..RATIO).
  - Output register: out_* signals.
- Reset (async, any time, including mid-line or mid-stall):
  - out_valid=0, out_data=0, out_mask=0, out_addr=0.
  - asm_cnt=0, asm_data=0; partial line is discarded.
  - in_ready=0 while rst=1.
- Output free (free): out_valid==0 OR out_ready==1.
- in_ready = free AND NOT rst. It depends only on output state, never on in_*.
- Accept occurs when in_valid AND in_ready.
- Expected address exp = asm_addr + asm_cnt, modulo 2^ADDR_W. Wrap from 2^ADDR_W-1 to 0 counts as contiguous.
- Accept into empty assembly (asm_cnt==0):
  - Beat goes to lane 0; asm_addr=in_addr; asm_cnt=1.
- Accept into non-empty assembly with in_addr==exp:
  - Beat goes to lane asm_cnt; asm_cnt+1.
- Accept into non-empty assembly with in_addr!=exp (discontinuity), in the same edge:
  - The existing partial line moves to the output register.
  - The new beat starts a fresh assembly at lane 0 with asm_cnt=1.
- Line close: a beat that fills lane RATIO-1, or a beat with in_last=1.
  - On the edge that accepts it, the line including that beat loads into the output register and the assembly resets to 0.
- Discontinuity combined with in_last or a single-beat line:
  - Old partial line goes to output; new beat stays in assembly; in_last is ignored for that beat.
  - Recorded as a protocol rule: upstream asserts in_last only on contiguous beats.
- Latency: closing beat accepted at edge N → out_valid=1 after edge N. Throughput is one beat per clock when out_ready stays 1.
- Unwritten lanes in out_data are 0; out_mask marks the written lanes.
- Output handshake:
  - out_* hold stable while out_valid=1 and out_ready=0.
  - out_valid falls after the accepting edge unless a new line loads on the same edge.
- Idle with partial line: the assembly holds indefinitely; there is no timeout. Upstream flushes with in_last.
- Output stall: in_ready=0, so no beats are accepted and the assembly is untouched.

Decomposition:
- Shared package pod_noc_pkg holds:
  - D_W, OFFCHIP_DW, ADDR_W, RATIO, CNT_W.
  - Lane-slice helper function lane_sel(k).
  - These are shared with pod_memory and the matching unpacker.
- Sub-module pod_line_oreg: output holding register with valid/ready, load, and hold logic.
- Assembly, address compare and lane counter stay in the top module.

Test Plan:
- Full contiguous line:
  - Stimulus: 8 beats at addr 0x0010..0x0017, data 0x1..0x8, out_ready=1.
  - Required: one line at out_addr=0x0010, out_mask=0xFF, lane k = k+1, out_valid exactly 1 cycle after the 8th accept.
- Early close:
  - Stimulus: 3 beats at 0x0100..0x0102, third with in_last=1.
  - Required: out_mask=0x07, out_addr=0x0100, lanes 3..7 = 0.
- Discontinuity:
  - Stimulus: beats at 0x0020, 0x0021, then 0x0040.
  - Required: line {0x0020, mask 0x03} emitted; 0x0040 held as lane 0 of the next line; in_ready stays 1 throughout.
- Backpressure:
  - Stimulus: completed line with out_ready=0 for 5 cycles while in_valid=1.
  - Required: in_ready=0; out_data and out_addr stable; no beat lost; accept resumes the cycle out_ready=1.
- Address wrap:
  - Stimulus: beats at 0x3FFE, 0x3FFF, 0x0000, 0x0001 with in_last=1.
  - Required: single line, out_addr=0x3FFE, mask 0x0F.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously after 4 beats, with an output line pending.
  - Required: out_valid=0, out_mask=0 and in_ready=0 immediately; after release, the first line contains only new beats.

Source files
------------

// File: rtl/pod_line_packer_pkg.sv
// Shared pod NoC sizing and lane helpers.
// Used by the line packer, pod memory and the unpacker.
package pod_noc_pkg;

    localparam int D_W        = 64;
    localparam int OFFCHIP_DW = 512;
    localparam int ADDR_W     = 14;
    localparam int RATIO      = OFFCHIP_DW / D_W;
    localparam int CNT_W      = $clog2(RATIO) + 1;
    localparam int LANE_W     = $clog2(RATIO);
    localparam int OFF_W      = $clog2(OFFCHIP_DW);

    // Bit offset of lane k inside a line.
    function automatic logic [OFF_W-1:0] lane_sel(
        input logic [LANE_W-1:0] k
    );
        return OFF_W'(k) * OFF_W'(D_W);
    endfunction

    // Mask with the lowest n lanes set.
    function automatic logic [RATIO-1:0] mask_of(
        input logic [CNT_W-1:0] n
    );
        logic [RATIO-1:0] m;
        m = '0;
        for (int i = 0; i < RATIO; i++) begin
            m[i] = (i < int'(n));
        end
        return m;
    endfunction

endpackage

// File: rtl/pod_line_packer_if.sv
// Beat input and line output handshake bundle.
// Master is the upstream feeder side; slave is the packer.
interface pod_line_packer_if;
    import pod_noc_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_W-1:0]     in_addr;
    logic [D_W-1:0]        in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_W-1:0]     out_addr;
    logic [OFFCHIP_DW-1:0] out_data;
    logic [RATIO-1:0]      out_mask;

    modport master (
        output in_valid, in_addr, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_addr, out_data, out_mask
    );

    modport slave (
        input  in_valid, in_addr, in_data, in_last, out_ready,
        output in_ready, out_valid, out_addr, out_data, out_mask
    );

endinterface

// File: rtl/pod_line_oreg.sv
// Output holding register for packed lines.
// Loads only when free, holds while stalled.
module pod_line_oreg
    import pod_noc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [OFFCHIP_DW-1:0] ld_data,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [RATIO-1:0]      ld_mask,
    input  logic                  ready,
    output logic                  valid,
    output logic [OFFCHIP_DW-1:0] data,
    output logic [ADDR_W-1:0]     addr,
    output logic [RATIO-1:0]      mask
);

    // Capture a new line, or drop valid once it is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            addr  <= '0;
            mask  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= ld_data;
            addr  <= ld_addr;
            mask  <= ld_mask;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pod_line_packer.sv
// Packs contiguous-address beats into one off-chip line.
// Discontinuity, a full line or in_last closes the line.
module pod_line_packer
    import pod_noc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    pod_line_packer_if.slave bus
);

    logic [OFFCHIP_DW-1:0] asm_data, nxt_data, merged;
    logic [ADDR_W-1:0]     asm_addr, nxt_addr, base;
    logic [CNT_W-1:0]      asm_cnt, nxt_cnt;
    logic [ADDR_W-1:0]     exp_addr;
    logic                  empty, contig, acc, free;
    logic                  ld;
    logic [OFFCHIP_DW-1:0] ld_data;
    logic [ADDR_W-1:0]     ld_addr;
    logic [RATIO-1:0]      ld_mask;
    logic                  o_valid;
    logic [OFFCHIP_DW-1:0] o_data;
    logic [ADDR_W-1:0]     o_addr;
    logic [RATIO-1:0]      o_mask;

    assign free         = !o_valid || bus.out_ready;
    assign bus.in_ready = free && !rst;
    assign acc          = bus.in_valid && bus.in_ready;
    assign exp_addr     = asm_addr + ADDR_W'(asm_cnt);
    assign empty        = (asm_cnt == '0);
    assign contig       = !empty && (bus.in_addr == exp_addr);

    // Next assembly state and the line handed to the output register.
    always_comb begin
        nxt_data = asm_data;
        nxt_addr = asm_addr;
        nxt_cnt  = asm_cnt;
        ld       = 1'b0;
        ld_data  = asm_data;
        ld_addr  = asm_addr;
        ld_mask  = mask_of(asm_cnt);
        merged   = asm_data;
        merged[lane_sel(asm_cnt[LANE_W-1:0]) +: D_W] = bus.in_data;
        base     = empty ? bus.in_addr : asm_addr;
        if (acc) begin
            if (empty || contig) begin
                if (bus.in_last || asm_cnt == CNT_W'(RATIO - 1)) begin
                    ld       = 1'b1;
                    ld_data  = merged;
                    ld_addr  = base;
                    ld_mask  = mask_of(asm_cnt + CNT_W'(1));
                    nxt_data = '0;
                    nxt_addr = base;
                    nxt_cnt  = '0;
                end else begin
                    nxt_data = merged;
                    nxt_addr = base;
                    nxt_cnt  = asm_cnt + CNT_W'(1);
                end
            end else begin
                ld       = 1'b1;
                nxt_data = '0;
                nxt_data[D_W-1:0] = bus.in_data;
                nxt_addr = bus.in_addr;
                nxt_cnt  = CNT_W'(1);
            end
        end
    end

    // Assembly buffer registers; reset discards any partial line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_data <= '0;
            asm_addr <= '0;
            asm_cnt  <= '0;
        end else begin
            asm_data <= nxt_data;
            asm_addr <= nxt_addr;
            asm_cnt  <= nxt_cnt;
        end
    end

    pod_line_oreg u_oreg (
        .clk     (clk),
        .rst     (rst),
        .load    (ld),
        .ld_data (ld_data),
        .ld_addr (ld_addr),
        .ld_mask (ld_mask),
        .ready   (bus.out_ready),
        .valid   (o_valid),
        .data    (o_data),
        .addr    (o_addr),
        .mask    (o_mask)
    );

    assign bus.out_valid = o_valid;
    assign bus.out_data  = o_data;
    assign bus.out_addr  = o_addr;
    assign bus.out_mask  = o_mask;

endmodule

// File: tb/tb_pod_line_packer.sv
// Bench for pod_line_packer: directed cases plus random traffic
// checked against a beat-list model of line packing.
module tb_pod_line_packer;
    import pod_noc_pkg::*;

    typedef logic [OFFCHIP_DW-1:0] wide_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        wide_t             data;
        logic [RATIO-1:0]  mask;
    } line_t;

    typedef struct {
        string name;
        wide_t act;
        wide_t exp;
    } lit_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pod_line_packer_if bus ();

    pod_line_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    line_t             exp_q[$];
    lit_t              lit_q[$];
    int                pass_cnt = 0;
    int                total_cnt = 0;
    int                m_cnt = 0;
    logic [ADDR_W-1:0] m_base = '0;
    wide_t             m_data = '0;
    bit                prev_stall = 1'b0;
    line_t             held;
    bit                rdone = 1'b0;

    function automatic void cmp(string name, wide_t act, wide_t exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endfunction

    function automatic void push_line();
        line_t l;
        l.addr = m_base;
        l.data = m_data;
        l.mask = RATIO'((1 << m_cnt) - 1);
        exp_q.push_back(l);
    endfunction

    function automatic void model_accept(
        logic [ADDR_W-1:0] a, logic [D_W-1:0] d, logic l
    );
        logic [ADDR_W-1:0] nxt;
        nxt = m_base + ADDR_W'(m_cnt);
        if (m_cnt == 0) begin
            m_base = a;
            m_data = '0;
            m_data[D_W-1:0] = d;
            m_cnt = 1;
        end else if (a == nxt) begin
            m_data[m_cnt*D_W +: D_W] = d;
            m_cnt++;
        end else begin
            push_line();
            m_base = a;
            m_data = '0;
            m_data[D_W-1:0] = d;
            m_cnt = 1;
            return;
        end
        if (l || m_cnt == RATIO) begin
            push_line();
            m_cnt = 0;
            m_data = '0;
        end
    endfunction

    // Single compare process: literal checks plus model checks.
    always @(negedge clk) begin : compare
        lit_t  t;
        line_t l;
        while (lit_q.size() > 0) begin
            t = lit_q.pop_front();
            cmp(t.name, t.act, t.exp);
        end
        if (rst) begin
            exp_q.delete();
            m_cnt = 0;
            m_data = '0;
            m_base = '0;
            prev_stall = 1'b0;
        end else begin
            cmp("in_ready_rule", wide_t'(bus.in_ready),
                wide_t'(!bus.out_valid || bus.out_ready));
            cmp("out_valid", wide_t'(bus.out_valid),
                wide_t'(exp_q.size() != 0));
            if (prev_stall) begin
                cmp("hold_addr", wide_t'(bus.out_addr), wide_t'(held.addr));
                cmp("hold_mask", wide_t'(bus.out_mask), wide_t'(held.mask));
                cmp("hold_data", bus.out_data, held.data);
            end
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
                l = exp_q.pop_front();
                cmp("line_addr", wide_t'(bus.out_addr), wide_t'(l.addr));
                cmp("line_mask", wide_t'(bus.out_mask), wide_t'(l.mask));
                cmp("line_data", bus.out_data, l.data);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held.addr = bus.out_addr;
            held.mask = bus.out_mask;
            held.data = bus.out_data;
            if (bus.in_valid && bus.in_ready)
                model_accept(bus.in_addr, bus.in_data, bus.in_last);
        end
    end

    task automatic lit(string n, wide_t a, wide_t e);
        lit_t t;
        t.name = n;
        t.act = a;
        t.exp = e;
        lit_q.push_back(t);
    endtask

    task automatic send_beat(
        input logic [ADDR_W-1:0] a, input logic [D_W-1:0] d,
        input logic l, output int waited
    );
        bus.in_valid = 1'b1;
        bus.in_addr = a;
        bus.in_data = d;
        bus.in_last = l;
        waited = 0;
        while (waited < 200) begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
        end
        if (waited >= 200) lit("accept_timeout", wide_t'(0), wide_t'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
    endtask

    initial begin : stim
        int    w;
        wide_t e;
        logic [ADDR_W-1:0] a;
        logic [D_W-1:0]    d;
        logic              l;
        bus.in_valid = 1'b0;
        bus.in_addr = '0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b1;
        #3;
        lit("rst_in_ready", wide_t'(bus.in_ready), wide_t'(0));
        lit("rst_out_valid", wide_t'(bus.out_valid), wide_t'(0));
        lit("rst_out_mask", wide_t'(bus.out_mask), wide_t'(0));
        lit("rst_out_data", bus.out_data, wide_t'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // full contiguous line
        e = '0;
        for (int k = 0; k < 8; k++) begin
            send_beat(ADDR_W'(16 + k), D_W'(k + 1), 1'b0, w);
            e[k*D_W +: D_W] = D_W'(k + 1);
            if (k == 6) lit("full_early", wide_t'(bus.out_valid), wide_t'(0));
        end
        lit("full_valid", wide_t'(bus.out_valid), wide_t'(1));
        lit("full_addr", wide_t'(bus.out_addr), wide_t'(16'h0010));
        lit("full_mask", wide_t'(bus.out_mask), wide_t'(8'hFF));
        lit("full_data", bus.out_data, e);

        // early close
        for (int k = 0; k < 3; k++)
            send_beat(ADDR_W'(256 + k), D_W'(k + 32'hA0), k == 2, w);
        lit("early_addr", wide_t'(bus.out_addr), wide_t'(16'h0100));
        lit("early_mask", wide_t'(bus.out_mask), wide_t'(8'h07));
        lit("early_hi0", wide_t'(bus.out_data[OFFCHIP_DW-1:3*D_W]),
            wide_t'(0));
        lit("early_l2", wide_t'(bus.out_data[2*D_W +: D_W]),
            wide_t'(32'hA2));

        // discontinuity
        send_beat(14'h0020, 64'h21, 1'b0, w);
        lit("disc_rdy0", wide_t'(w), wide_t'(0));
        send_beat(14'h0021, 64'h22, 1'b0, w);
        lit("disc_rdy1", wide_t'(w), wide_t'(0));
        send_beat(14'h0040, 64'h41, 1'b0, w);
        lit("disc_rdy2", wide_t'(w), wide_t'(0));
        lit("disc_addr", wide_t'(bus.out_addr), wide_t'(16'h0020));
        lit("disc_mask", wide_t'(bus.out_mask), wide_t'(8'h03));
        lit("disc_l1", wide_t'(bus.out_data[D_W +: D_W]), wide_t'(8'h22));
        send_beat(14'h0041, 64'h42, 1'b1, w);
        lit("disc_next_addr", wide_t'(bus.out_addr), wide_t'(16'h0040));
        lit("disc_next_l0", wide_t'(bus.out_data[D_W-1:0]), wide_t'(8'h41));

        // backpressure
        for (int k = 0; k < 8; k++)
            send_beat(ADDR_W'(14'h1000 + k), {$urandom, $urandom}, 1'b0, w);
        bus.out_ready = 1'b0;
        fork
            send_beat(14'h2000, 64'hBEEF, 1'b0, w);
            begin
                repeat (5) begin
                    @(negedge clk);
                    lit("bp_in_ready", wide_t'(bus.in_ready), wide_t'(0));
                    lit("bp_addr", wide_t'(bus.out_addr), wide_t'(16'h1000));
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        lit("bp_resume", wide_t'(w), wide_t'(5));
        send_beat(14'h2001, 64'hCAFE, 1'b1, w);

        // address wrap
        send_beat(14'h3FFE, 64'h1, 1'b0, w);
        send_beat(14'h3FFF, 64'h2, 1'b0, w);
        send_beat(14'h0000, 64'h3, 1'b0, w);
        send_beat(14'h0001, 64'h4, 1'b1, w);
        lit("wrap_addr", wide_t'(bus.out_addr), wide_t'(16'h3FFE));
        lit("wrap_mask", wide_t'(bus.out_mask), wide_t'(8'h0F));

        // reset mid-operation with a line pending
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            send_beat(ADDR_W'(14'h0200 + k), D_W'(k + 9), 1'b0, w);
        send_beat(14'h0300, 64'h77, 1'b0, w);
        lit("pre_rst_pending", wide_t'(bus.out_valid), wide_t'(1));
        #2 rst = 1'b1;
        #1;
        lit("mid_rst_valid", wide_t'(bus.out_valid), wide_t'(0));
        lit("mid_rst_mask", wide_t'(bus.out_mask), wide_t'(0));
        lit("mid_rst_ready", wide_t'(bus.in_ready), wide_t'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        send_beat(14'h0500, 64'h51, 1'b0, w);
        send_beat(14'h0501, 64'h52, 1'b1, w);
        lit("post_rst_addr", wide_t'(bus.out_addr), wide_t'(16'h0500));
        lit("post_rst_mask", wide_t'(bus.out_mask), wide_t'(8'h03));
        lit("post_rst_l0", wide_t'(bus.out_data[D_W-1:0]), wide_t'(8'h51));

        // random traffic
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    if (m_cnt > 0 && $urandom_range(3) != 0)
                        a = m_base + ADDR_W'(m_cnt);
                    else
                        a = ADDR_W'($urandom);
                    d = {$urandom, $urandom};
                    l = ($urandom_range(4) == 0);
                    send_beat(a, d, l, w);
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(2) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
